mem_arbiter: RTL and testbench

Two-port arbiter sharing the single 128 x 32-bit unified RAM between the instruction-fetch unit and the load/store unit. It serializes accesses through a small state machine, inserts a configurable number of wait states per access, and returns read data and a one-cycle acknowledge to the winning requester. Data accesses have priority; a starvation counter guarantees fetch progress. Sits between the CPU front/back ends and the RAM's address, data and write-enable pins.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 46 ++++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the unified-RAM arbiter: FSM state encoding,
//   access-owner identifiers, default bus widths and the width of the
//   small wait/starvation counters (both parameters are limited to 1..15).
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 7;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Winner selection for the two RAM requesters. Data wins a tie unless it
//   has already won STARVE_LIMIT consecutive ties against a pending fetch,
//   in which case fetch is forced through.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-low reset
//   if_req        fetch request pending
//   d_req         data request pending
//   grant         arbiter is accepting a request this cycle
//   pick_d        1: data wins, 0: fetch wins (only meaningful with a request)
module mem_arb_pick import mem_arb_pkg::*; #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic grant,
    output logic pick_d
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    always_comb begin
        pick_d = d_req;
        if (if_req && (starve_cnt == LIMIT)) begin
            pick_d = 1'b0;
        end
    end

    // Counts only the data wins that actually made a fetch wait.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (!pick_d) begin
                starve_cnt <= '0;
            end else if (if_req && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Serialises instruction-fetch and load/store accesses onto a single
//   unified RAM with a combinational read port. Each access holds the RAM
//   for WAIT_CYCLES cycles, then the owner gets a one-cycle acknowledge.
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   if_req/if_addr         fetch request and word address
//   if_rdata/if_ack        fetch read data (held) and completion pulse
//   d_req/d_we/d_addr      data request, write enable, word address
//   d_wdata                data write data
//   d_rdata/d_ack          data read data (held) and completion pulse
//   ram_addr/ram_wdata     RAM address and write data
//   ram_wre                RAM write enable (one cycle, end of a write)
//   ram_rdata              RAM read data
//   busy                   access in progress (BUSY or ACK)
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wre,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic             SHORT_WAIT = (WAIT_CYCLES == 1);

    arb_state_t       state;
    owner_t           owner;
    logic             we_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             grant;
    logic             pick_d;

    assign grant = (state == IDLE) && (if_req || d_req);

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clock  (clock),
        .reset  (reset),
        .if_req (if_req),
        .d_req  (d_req),
        .grant  (grant),
        .pick_d (pick_d)
    );

    // ram_wre is registered one cycle ahead: it is set on the edge that
    // brings wait_cnt to zero, so it is high exactly for the BUSY cycle
    // with wait_cnt == 0 of a write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            we_q      <= 1'b0;
            wait_cnt  <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wre   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state    <= BUSY;
                        busy     <= 1'b1;
                        wait_cnt <= WAIT_LOAD;
                        if (pick_d) begin
                            owner     <= OWN_D;
                            ram_addr  <= d_addr;
                            ram_wdata <= d_wdata;
                            we_q      <= d_we;
                            ram_wre   <= d_we && SHORT_WAIT;
                        end else begin
                            owner     <= OWN_IF;
                            ram_addr  <= if_addr;
                            ram_wdata <= '0;
                            we_q      <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (wait_cnt == '0) begin
                        state   <= ACK;
                        ram_wre <= 1'b0;
                        if (owner == OWN_D) begin
                            d_ack <= 1'b1;
                            if (!we_q) begin
                                d_rdata <= ram_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= ram_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                        ram_wre  <= we_q && (wait_cnt == CNT_W'(1));
                    end
                end
                ACK: begin
                    state  <= IDLE;
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter (WAIT_CYCLES=3, STARVE_LIMIT=4) with a
//   transaction-level model checked every cycle plus literal expectations.
module tb_mem_arbiter;

    localparam int W     = 3;
    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [6:0]  if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [6:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [6:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wre;
    logic [31:0] ram_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram_mem   [128];
    logic [31:0] model_mem [128];

    always #5 clock = ~clock;

    mem_arbiter #(
        .ADDR_W       (7),
        .DATA_W       (32),
        .WAIT_CYCLES  (W),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wre   (ram_wre),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    // RAM attached to the arbiter's pins
    assign ram_rdata = ram_mem[ram_addr];
    always @(posedge clock) if (ram_wre) ram_mem[ram_addr] <= ram_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Transaction model: an access granted at edge g occupies cycles g..g+W,
    // write lands / read is captured at edge g+W, ack is cycle g+W.
    int          cyc = 0;
    bit          m_act = 0;
    int          m_g = 0;
    bit          m_d = 0;
    bit          m_we = 0;
    logic [6:0]  m_addr = '0;
    logic [31:0] m_wdata = '0;
    int          m_starve = 0;
    logic [31:0] m_if_rd = '0;
    logic [31:0] m_d_rd = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc = 0; m_act = 0; m_starve = 0; m_if_rd = '0; m_d_rd = '0;
        end else begin
            cyc++;
            if (m_act && cyc == m_g + W) begin
                if (m_we) model_mem[m_addr] = m_wdata;
                else if (m_d) m_d_rd = model_mem[m_addr];
                else m_if_rd = model_mem[m_addr];
            end
            if (m_act && cyc == m_g + W + 1) begin
                m_act = 0;
            end else if (!m_act && (if_req || d_req)) begin
                m_act = 1;
                m_g   = cyc;
                m_d   = d_req && !(if_req && m_starve >= LIMIT);
                if (m_d) begin
                    if (if_req) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
                    m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                end else begin
                    m_starve = 0;
                    m_we = 0; m_addr = if_addr; m_wdata = '0;
                end
            end
        end
    end

    int wre_cnt = 0, busy_cnt = 0, if_ack_cnt = 0;

    always @(negedge clock) begin
        chk("busy",     busy,     m_act);
        chk("ram_wre",  ram_wre,  m_act && m_we && cyc == m_g + W - 1);
        chk("if_ack",   if_ack,   m_act && !m_d && cyc == m_g + W);
        chk("d_ack",    d_ack,    m_act && m_d && cyc == m_g + W);
        chk("if_rdata", if_rdata, m_if_rd);
        chk("d_rdata",  d_rdata,  m_d_rd);
        if (m_act && cyc < m_g + W) begin
            chk("ram_addr", ram_addr, m_addr);
            if (m_we) chk("ram_wdata", ram_wdata, m_wdata);
        end
        if (!reset) begin
            chk("rst_ram_addr", ram_addr, 32'd0);
            chk("rst_ram_wdata", ram_wdata, 32'd0);
        end
        if (m_act && m_we && cyc == m_g + W) chk("ram_word", ram_mem[m_addr], model_mem[m_addr]);
        wre_cnt    += ram_wre;
        busy_cnt   += busy;
        if_ack_cnt += if_ack;
    end

    task automatic wait_ack(input bit isd, output int n);
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!(isd ? d_ack : if_ack) && n < 40);
        if (!(isd ? d_ack : if_ack)) begin
            total++; bad++;
            $display("FAIL ack_timeout: no ack after %0d cycles, want within 40", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int lat, w0, b0, i0, a1, a2, k, n;
        byte got;
        string exp_order;
        exp_order = "DDDDIDDDDI";
        for (int i = 0; i < 128; i++) begin
            ram_mem[i]   <= 32'hA5A50000 + i;
            model_mem[i]  = 32'hA5A50000 + i;
        end
        ram_mem[10]   <= 32'h2009000A;
        model_mem[10]  = 32'h2009000A;

        #2 reset = 1'b0;
        #1;
        chk("rst_busy", busy, 32'd0);
        chk("rst_wre", ram_wre, 32'd0);
        chk("rst_dack", d_ack, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // single data write
        w0 = wre_cnt; b0 = busy_cnt; i0 = if_ack_cnt;
        d_addr = 7'd5; d_wdata = 32'hDEADBEEF; d_we = 1'b1; d_req = 1'b1;
        wait_ack(1'b1, lat);
        chk("wr_latency", lat, 32'd4);
        @(posedge clock); #1 d_req = 1'b0; d_we = 1'b0;
        chk("wr_wre_cycles", wre_cnt - w0, 32'd1);
        chk("wr_busy_cycles", busy_cnt - b0, 32'd4);
        chk("wr_no_if_ack", if_ack_cnt - i0, 32'd0);
        chk("wr_ram5", ram_mem[5], 32'hDEADBEEF);

        // single fetch read
        w0 = wre_cnt; b0 = busy_cnt;
        if_addr = 7'd10; if_req = 1'b1;
        wait_ack(1'b0, lat);
        chk("if_latency", lat, 32'd4);
        chk("if_rdata_lit", if_rdata, 32'h2009000A);
        @(posedge clock); #1 if_req = 1'b0;
        chk("if_wre_cycles", wre_cnt - w0, 32'd0);
        chk("if_busy_cycles", busy_cnt - b0, 32'd4);

        // data read of the earlier write
        d_addr = 7'd5; d_we = 1'b0; d_req = 1'b1;
        wait_ack(1'b1, lat);
        chk("rd_rdata_lit", d_rdata, 32'hDEADBEEF);
        @(posedge clock); #1 d_req = 1'b0;

        // contention with starvation
        if_addr = 7'd10; d_addr = 7'd5; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (k = 0; k < 10; k++) begin
            n = 0;
            do begin
                @(posedge clock); #1; n++;
            end while (!(if_ack || d_ack) && n < 40);
            got = d_ack ? "D" : (if_ack ? "I" : "-");
            chk("grant_order", got, exp_order[k]);
        end
        @(posedge clock); #1 if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clock); #1;

        // back-to-back data writes with req held through ack
        d_we = 1'b1; d_addr = 7'd20; d_wdata = 32'h11111111; d_req = 1'b1;
        wait_ack(1'b1, lat);
        a1 = cyc;
        @(posedge clock); #1 d_addr = 7'd21; d_wdata = 32'h22222222;
        wait_ack(1'b1, lat);
        a2 = cyc;
        chk("b2b_gap", a2 - a1, 32'd5);
        @(posedge clock); #1 d_req = 1'b0; d_we = 1'b0;
        chk("b2b_ram20", ram_mem[20], 32'h11111111);
        chk("b2b_ram21", ram_mem[21], 32'h22222222);

        // reset in the middle of a write
        w0 = wre_cnt;
        d_we = 1'b1; d_addr = 7'd30; d_wdata = 32'h12345678; d_req = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("mid_busy", busy, 32'd0);
        chk("mid_wre", ram_wre, 32'd0);
        chk("mid_dack", d_ack, 32'd0);
        chk("mid_ifack", if_ack, 32'd0);
        chk("mid_addr", ram_addr, 32'd0);
        chk("mid_wdata", ram_wdata, 32'd0);
        chk("mid_drdata", d_rdata, 32'd0);
        chk("mid_ifrdata", if_rdata, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("mid_ram30", ram_mem[30], 32'hA5A5001E);
        chk("mid_wre_cycles", wre_cnt - w0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
